// File: rtl/pc.sv
// Fetch-stage program counter: holds the current instruction address and loads
// the upstream next-PC value when the stage is enabled and not stalled.
module pc #(
   parameter int unsigned          WIDTH        = 32,
   parameter logic [WIDTH-1:0]     RESET_VECTOR = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clk_en,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_di,
   output logic [WIDTH-1:0] o_do
);

   // Stage enable and hazard stall both freeze the PC; reset dominates everything.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_do <= RESET_VECTOR;
      end else if (i_clk_en && i_wr_en) begin
         o_do <= i_di;
      end
   end

endmodule

// File: tb/tb_pc.sv
// Scoreboard bench for pc: stimulus pushes hand-computed expectations, monitors
// pop and compare them against two instances (default and 0x100 reset vector).
module tb_pc;

   localparam int unsigned W      = 32;
   localparam logic [W-1:0] RV_ALT = 32'h0000_0100;

   typedef struct {
      bit          hold;
      logic [W-1:0] e0;
      logic [W-1:0] e1;
      string        name;
   } item_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         clk_en = 1'b0;
   logic         wr_en = 1'b0;
   logic [W-1:0] di = '0;
   logic [W-1:0] do0;
   logic [W-1:0] do1;

   item_t sync_q[$];
   item_t async_q[$];
   event  async_ev;

   int n_vec = 0;
   int n_err = 0;

   pc #(.WIDTH(W)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_wr_en(wr_en),
      .i_di(di), .o_do(do0)
   );

   pc #(.WIDTH(W), .RESET_VECTOR(RV_ALT)) u_dut_rv (
      .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_wr_en(wr_en),
      .i_di(di), .o_do(do1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Edge-driven monitor: one expectation per rising edge while the queue is non-empty.
   initial begin
      logic [W-1:0] pre0, pre1;
      item_t it;
      forever begin
         @(negedge clk);
         pre0 = do0;
         pre1 = do1;
         @(posedge clk);
         #1;
         if (sync_q.size() > 0) begin
            it = sync_q.pop_front();
            if (it.hold) begin
               check({it.name, "/rv0"}, do0, pre0);
               check({it.name, "/rv100"}, do1, pre1);
            end else begin
               check({it.name, "/rv0"}, do0, it.e0);
               check({it.name, "/rv100"}, do1, it.e1);
            end
         end
      end
   end

   // Asynchronous-reset monitor: checks output between clock edges.
   initial begin
      item_t it;
      forever begin
         @(async_ev);
         #1;
         if (async_q.size() > 0) begin
            it = async_q.pop_front();
            check({it.name, "/rv0"}, do0, it.e0);
            check({it.name, "/rv100"}, do1, it.e1);
         end
      end
   end

   task automatic step(input logic r, input logic ce, input logic we, input logic [W-1:0] d,
                       input logic [W-1:0] e0, input logic [W-1:0] e1, input string name);
      item_t it;
      @(negedge clk);
      rst    = r;
      clk_en = ce;
      wr_en  = we;
      di     = d;
      it.hold = 1'b0; it.e0 = e0; it.e1 = e1; it.name = name;
      sync_q.push_back(it);
   endtask

   task automatic step_hold(input logic ce, input logic we, input logic [W-1:0] d, input string name);
      item_t it;
      @(negedge clk);
      clk_en = ce;
      wr_en  = we;
      di     = d;
      it.hold = 1'b1; it.e0 = '0; it.e1 = '0; it.name = name;
      sync_q.push_back(it);
   endtask

   task automatic async_rst(input logic [W-1:0] d, input string name);
      item_t it;
      @(posedge clk);
      #3;
      rst    = 1'b1;
      clk_en = 1'b1;
      wr_en  = 1'b1;
      di     = d;
      it.hold = 1'b0; it.e0 = 32'h0; it.e1 = RV_ALT; it.name = name;
      async_q.push_back(it);
      -> async_ev;
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time bound, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // Before any reset: disabled stage must not load.
      step_hold(1'b0, 1'b1, 32'd12, "prereset_hold_a");
      step_hold(1'b0, 1'b1, 32'd12, "prereset_hold_b");

      // Reset asserted mid-cycle, then held across edges with a write pending.
      async_rst(32'd12, "rst_immediate");
      step(1'b1, 1'b1, 1'b1, 32'd12, 32'h0, RV_ALT, "rst_hold_a");
      step(1'b1, 1'b1, 1'b1, 32'd12, 32'h0, RV_ALT, "rst_hold_b");

      // Release and first loads.
      step(1'b0, 1'b1, 1'b1, 32'd12, 32'd12, 32'd12, "first_load");
      step(1'b0, 1'b1, 1'b1, 32'd12, 32'd12, 32'd12, "steady_12");
      step(1'b0, 1'b1, 1'b1, 32'd4, 32'd4, 32'd4, "seq_4");
      step(1'b0, 1'b1, 1'b1, 32'd8, 32'd8, 32'd8, "seq_8");
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "seq_fffffffc");
      step(1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003, "misaligned_3");
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");

      // Stalls and stage-disable while next-PC keeps changing.
      step(1'b0, 1'b1, 1'b1, 32'd16, 32'd16, 32'd16, "load_16");
      step(1'b0, 1'b1, 1'b0, 32'd20, 32'd16, 32'd16, "stall_we0");
      step(1'b0, 1'b0, 1'b1, 32'd20, 32'd16, 32'd16, "stall_ce0");
      step(1'b0, 1'b0, 1'b0, 32'd24, 32'd16, 32'd16, "stall_both");
      step(1'b0, 1'b1, 1'b1, 32'd20, 32'd20, 32'd20, "load_20");

      // Mid-cycle reset while holding 20, then reset beating a write.
      async_rst(32'd28, "rst_mid_20");
      step(1'b1, 1'b1, 1'b1, 32'd28, 32'h0, RV_ALT, "rst_wins_write");
      step(1'b0, 1'b0, 1'b1, 32'd28, 32'h0, RV_ALT, "post_rst_ce0");
      step(1'b0, 1'b1, 1'b1, 32'd28, 32'd28, 32'd28, "resume_28");
      step(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, "resume_pattern");

      @(posedge clk);
      #3;
      n_vec++;
      if (sync_q.size() != 0 || async_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", sync_q.size() + async_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
